// File: rtl/qdr_usr_pkg.sv
// rtl/qdr_usr_pkg.sv - shared types, defaults and helpers for the QDR user-port requester
package qdr_usr_pkg;

  localparam int DEF_ADDR_WIDTH = 21;
  localparam int DEF_DATA_WIDTH = 72;
  localparam int DEF_BE_WIDTH   = 8;
  localparam int DEF_TAG_WIDTH  = 4;

  typedef enum logic [1:0] {
    WAIT_RDY = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2,
    ERR      = 2'd3
  } req_state_e;

  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
    logic [DEF_BE_WIDTH-1:0]   be;
    logic [DEF_TAG_WIDTH-1:0]  tag;
  } usr_cmd_t;

  // Counter width able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/qdr_usr_requester_if.sv
// rtl/qdr_usr_requester_if.sv - command, controller usr_* and response signals of the requester
interface qdr_usr_requester_if
  import qdr_usr_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BE_WIDTH   = DEF_BE_WIDTH,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [BE_WIDTH-1:0]   cmd_be;
  logic [TAG_WIDTH-1:0]  cmd_tag;

  logic [ADDR_WIDTH-1:0] usr_addr;
  logic                  usr_wr_strb;
  logic [DATA_WIDTH-1:0] usr_wr_data;
  logic [BE_WIDTH-1:0]   usr_wr_be;
  logic                  usr_rd_strb;
  logic [DATA_WIDTH-1:0] usr_rd_data;
  logic                  usr_rd_dvld;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [TAG_WIDTH-1:0]  rsp_tag;

  // master is the requester (drives the controller's usr_* port)
  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_be, cmd_tag,
    input  usr_rd_data, usr_rd_dvld,
    output cmd_ready, usr_addr, usr_wr_strb, usr_wr_data, usr_wr_be, usr_rd_strb,
    output rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_be, cmd_tag,
    output usr_rd_data, usr_rd_dvld,
    input  cmd_ready, usr_addr, usr_wr_strb, usr_wr_data, usr_wr_be, usr_rd_strb,
    input  rsp_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/qdr_tag_fifo.sv
// rtl/qdr_tag_fifo.sv - synchronous tag FIFO holding tags of outstanding reads
module qdr_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/qdr_usr_requester.sv
// rtl/qdr_usr_requester.sv - tagged command stream to QDR usr_* strobes with in-order tagged read returns
// Optional strobe/high-water statistics outputs under QDR_USR_REQUESTER_STATS_EN.
module qdr_usr_requester
  import qdr_usr_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BE_WIDTH   = DEF_BE_WIDTH,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int MAX_OUTST  = 16,
  parameter int RD_TIMEOUT = 1024
) (
  input  logic                        clk0_i,
  input  logic                        reset_i,
  input  logic                        phy_rdy_i,
  qdr_usr_requester_if.master         bus,
  output logic [$clog2(MAX_OUTST):0]  outst_cnt_o,
  output logic                        err_timeout_o,
  output logic                        err_unexp_o
`ifdef QDR_USR_REQUESTER_STATS_EN
  ,
  output logic [31:0]                 stat_wr_cnt_o,
  output logic [31:0]                 stat_rd_cnt_o,
  output logic [$clog2(MAX_OUTST):0]  stat_max_outst_o
`endif
);
  localparam int              CW      = cnt_width(MAX_OUTST);
  localparam int              WW      = $clog2(RD_TIMEOUT + 1);
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_OUTST);
  localparam logic [WW-1:0]   WD_LAST = WW'(RD_TIMEOUT - 1);

  req_state_e            state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic [ADDR_WIDTH-1:0] usr_addr_q;
  logic                  usr_wr_strb_q, usr_rd_strb_q;
  logic [DATA_WIDTH-1:0] usr_wr_data_q;
  logic [BE_WIDTH-1:0]   usr_wr_be_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [TAG_WIDTH-1:0]  rsp_tag_q;
  logic [WW-1:0]         wd_q;
  logic                  err_timeout_q, err_unexp_q;

  logic                  accept, wr_accept, rd_accept, push, pop;
  logic                  fifo_empty, fifo_full, wd_run, wd_expire;
  logic [TAG_WIDTH-1:0]  fifo_head;
  logic [CW-1:0]         cnt_q, cnt_nxt;

  assign accept    = bus.cmd_valid & cmd_ready_q;
  assign wr_accept = accept & bus.cmd_we;
  assign rd_accept = accept & ~bus.cmd_we;
  assign push      = rd_accept & ~fifo_full;
  assign pop       = bus.usr_rd_dvld & ~fifo_empty;
  assign cnt_nxt   = cnt_q + CW'(push) - CW'(pop);
  assign wd_run    = (cnt_q != '0) & ~bus.usr_rd_dvld;
  assign wd_expire = wd_run & (wd_q == WD_LAST) & ((state_q == RUN) | (state_q == DRAIN));

  qdr_tag_fifo #(.DEPTH(MAX_OUTST), .WIDTH(TAG_WIDTH)) u_tag_fifo (
    .clk_i   (clk0_i),
    .reset_i (reset_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (bus.cmd_tag),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (cnt_q)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_RDY: if (phy_rdy_i) state_d = RUN;
      RUN:      if (wd_expire) state_d = ERR;
                else if (!phy_rdy_i) state_d = DRAIN;
      DRAIN:    if (wd_expire) state_d = ERR;
                else if (phy_rdy_i) state_d = RUN;
                else if (cnt_q == '0) state_d = WAIT_RDY;
      ERR:      state_d = ERR;
      default:  state_d = WAIT_RDY;
    endcase
    // Ready looks at next-cycle count so a read filling the last slot still lands.
    cmd_ready_d = (state_d == RUN) && (cnt_nxt < MAX_CNT);
  end

  always_ff @(posedge clk0_i) begin
    if (reset_i) begin
      state_q       <= WAIT_RDY;
      cmd_ready_q   <= 1'b0;
      usr_addr_q    <= '0;
      usr_wr_strb_q <= 1'b0;
      usr_rd_strb_q <= 1'b0;
      usr_wr_data_q <= '0;
      usr_wr_be_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_tag_q     <= '0;
      wd_q          <= '0;
      err_timeout_q <= 1'b0;
      err_unexp_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      usr_wr_strb_q <= wr_accept;
      usr_rd_strb_q <= rd_accept;
      if (accept) usr_addr_q <= bus.cmd_addr;
      if (wr_accept) begin
        usr_wr_data_q <= bus.cmd_wdata;
        usr_wr_be_q   <= bus.cmd_be;
      end
      rsp_valid_q <= bus.usr_rd_dvld;
      if (bus.usr_rd_dvld) begin
        rsp_data_q <= bus.usr_rd_data;
        rsp_tag_q  <= fifo_empty ? '0 : fifo_head;
      end
      if (bus.usr_rd_dvld && fifo_empty) err_unexp_q <= 1'b1;
      if (wd_expire) err_timeout_q <= 1'b1;
      if (!wd_run) wd_q <= '0;
      else if (wd_q != WD_LAST) wd_q <= wd_q + WW'(1);
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.usr_addr    = usr_addr_q;
  assign bus.usr_wr_strb = usr_wr_strb_q;
  assign bus.usr_wr_data = usr_wr_data_q;
  assign bus.usr_wr_be   = usr_wr_be_q;
  assign bus.usr_rd_strb = usr_rd_strb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_tag     = rsp_tag_q;
  assign outst_cnt_o     = cnt_q;
  assign err_timeout_o   = err_timeout_q;
  assign err_unexp_o     = err_unexp_q;

`ifdef QDR_USR_REQUESTER_STATS_EN
  logic [31:0]   stat_wr_q, stat_rd_q;
  logic [CW-1:0] stat_max_q;

  always_ff @(posedge clk0_i) begin
    if (reset_i) begin
      stat_wr_q  <= '0;
      stat_rd_q  <= '0;
      stat_max_q <= '0;
    end else begin
      if (usr_wr_strb_q) stat_wr_q <= stat_wr_q + 32'd1;
      if (usr_rd_strb_q) stat_rd_q <= stat_rd_q + 32'd1;
      if (cnt_nxt > stat_max_q) stat_max_q <= cnt_nxt;
    end
  end

  assign stat_wr_cnt_o    = stat_wr_q;
  assign stat_rd_cnt_o    = stat_rd_q;
  assign stat_max_outst_o = stat_max_q;
`endif
endmodule

// File: tb/tb_qdr_usr_requester.sv
// tb/tb_qdr_usr_requester.sv - directed vector table plus hand-written sequences for qdr_usr_requester
module tb_qdr_usr_requester;
  import qdr_usr_pkg::*;

  localparam int AW = 21, DW = 72, BW = 8, TW = 4, MO = 16, RT = 1024;
  localparam int CW = $clog2(MO) + 1;

  logic          clk0 = 1'b0;
  logic          reset = 1'b1;
  logic          phy_rdy = 1'b0;
  logic [CW-1:0] outst_cnt;
  logic          err_timeout, err_unexp;
`ifdef QDR_USR_REQUESTER_STATS_EN
  logic [31:0]   stat_wr_cnt, stat_rd_cnt;
  logic [CW-1:0] stat_max_outst;
`endif

  qdr_usr_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .TAG_WIDTH(TW)) bus ();

  qdr_usr_requester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .TAG_WIDTH(TW),
    .MAX_OUTST(MO), .RD_TIMEOUT(RT)
  ) dut (
    .clk0_i        (clk0),
    .reset_i       (reset),
    .phy_rdy_i     (phy_rdy),
    .bus           (bus),
    .outst_cnt_o   (outst_cnt),
    .err_timeout_o (err_timeout),
    .err_unexp_o   (err_unexp)
`ifdef QDR_USR_REQUESTER_STATS_EN
    ,
    .stat_wr_cnt_o    (stat_wr_cnt),
    .stat_rd_cnt_o    (stat_rd_cnt),
    .stat_max_outst_o (stat_max_outst)
`endif
  );

  always #5 clk0 = ~clk0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          valid, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic [TW-1:0] tag;
    logic          dvld;
    logic [DW-1:0] rdata;
    logic          x_ready, x_wr, x_rd;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata;
    logic [BW-1:0] x_be;
    logic          x_rsp;
    logic [TW-1:0] x_tag;
    logic [DW-1:0] x_rdata;
    logic [CW-1:0] x_cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  task automatic drive(input logic valid, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [BW-1:0] be, input logic [TW-1:0] tag,
                       input logic dvld, input logic [DW-1:0] rdata);
    bus.cmd_valid   = valid;
    bus.cmd_we      = we;
    bus.cmd_addr    = addr;
    bus.cmd_wdata   = wdata;
    bus.cmd_be      = be;
    bus.cmd_tag     = tag;
    bus.usr_rd_dvld = dvld;
    bus.usr_rd_data = rdata;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic rd(input logic [TW-1:0] tag, input logic dvld, input logic [DW-1:0] rdata);
    drive(1'b1, 1'b0, AW'(32'h300) + AW'(tag), '0, '0, tag, dvld, rdata);
  endtask

  task automatic ret(input logic [DW-1:0] rdata);
    drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, rdata);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic got;

    vecs[0] = '{1'b1, 1'b1, 21'h1ABCD, 72'h123456789ABCDEF012, 8'hFF, 4'h0, 1'b0, 72'h0,
                1'b1, 1'b1, 1'b0, 21'h1ABCD, 72'h123456789ABCDEF012, 8'hFF, 1'b0, 4'h0, 72'h0, 5'd0};
    vecs[1] = '{1'b0, 1'b0, 21'h0, 72'h0, 8'h00, 4'h0, 1'b0, 72'h0,
                1'b1, 1'b0, 1'b0, 21'h1ABCD, 72'h123456789ABCDEF012, 8'hFF, 1'b0, 4'h0, 72'h0, 5'd0};
    vecs[2] = '{1'b1, 1'b0, 21'h00010, 72'hDEAD, 8'h01, 4'h3, 1'b0, 72'h0,
                1'b1, 1'b0, 1'b1, 21'h00010, 72'h123456789ABCDEF012, 8'hFF, 1'b0, 4'h0, 72'h0, 5'd1};
    vecs[3] = '{1'b1, 1'b0, 21'h00011, 72'h0, 8'h00, 4'h5, 1'b0, 72'h0,
                1'b1, 1'b0, 1'b1, 21'h00011, 72'h123456789ABCDEF012, 8'hFF, 1'b0, 4'h0, 72'h0, 5'd2};
    vecs[4] = '{1'b1, 1'b1, 21'h00020, 72'hAA, 8'h0F, 4'h0, 1'b0, 72'h0,
                1'b1, 1'b1, 1'b0, 21'h00020, 72'hAA, 8'h0F, 1'b0, 4'h0, 72'h0, 5'd2};
    vecs[5] = '{1'b0, 1'b0, 21'h0, 72'h0, 8'h00, 4'h0, 1'b1, 72'h55,
                1'b1, 1'b0, 1'b0, 21'h00020, 72'hAA, 8'h0F, 1'b1, 4'h3, 72'h55, 5'd1};
    vecs[6] = '{1'b1, 1'b0, 21'h00012, 72'h0, 8'h00, 4'h9, 1'b1, 72'h66,
                1'b1, 1'b0, 1'b1, 21'h00012, 72'hAA, 8'h0F, 1'b1, 4'h5, 72'h66, 5'd1};
    vecs[7] = '{1'b0, 1'b0, 21'h0, 72'h0, 8'h00, 4'h0, 1'b1, 72'h77,
                1'b1, 1'b0, 1'b0, 21'h00012, 72'hAA, 8'h0F, 1'b1, 4'h9, 72'h77, 5'd0};
    vecs[8] = '{1'b0, 1'b0, 21'h0, 72'h0, 8'h00, 4'h0, 1'b0, 72'h0,
                1'b1, 1'b0, 1'b0, 21'h00012, 72'hAA, 8'h0F, 1'b0, 4'h0, 72'h0, 5'd0};

    // Reset and bring-up
    idle();
    step();
    step();
    check("rst ready", DW'(bus.cmd_ready), 72'd0);
    check("rst cnt", DW'(outst_cnt), 72'd0);
    check("rst wr_strb", DW'(bus.usr_wr_strb), 72'd0);
    check("rst rsp_valid", DW'(bus.rsp_valid), 72'd0);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      check($sformatf("wait_rdy ready c%0d", k), DW'(bus.cmd_ready), 72'd0);
    end
    phy_rdy = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 2 && !got; k++) begin
      step();
      got = bus.cmd_ready;
    end
    check("bringup ready", DW'(got), 72'd1);

    // Vector table: writes, reads, hold behaviour, in-order returns
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].valid, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].tag,
            vecs[i].dvld, vecs[i].rdata);
      step();
      check($sformatf("v%0d ready", i), DW'(bus.cmd_ready), DW'(vecs[i].x_ready));
      check($sformatf("v%0d wr_strb", i), DW'(bus.usr_wr_strb), DW'(vecs[i].x_wr));
      check($sformatf("v%0d rd_strb", i), DW'(bus.usr_rd_strb), DW'(vecs[i].x_rd));
      check($sformatf("v%0d addr", i), DW'(bus.usr_addr), DW'(vecs[i].x_addr));
      check($sformatf("v%0d wdata", i), bus.usr_wr_data, vecs[i].x_wdata);
      check($sformatf("v%0d be", i), DW'(bus.usr_wr_be), DW'(vecs[i].x_be));
      check($sformatf("v%0d rsp_valid", i), DW'(bus.rsp_valid), DW'(vecs[i].x_rsp));
      if (vecs[i].x_rsp) begin
        check($sformatf("v%0d rsp_tag", i), DW'(bus.rsp_tag), DW'(vecs[i].x_tag));
        check($sformatf("v%0d rsp_data", i), bus.rsp_data, vecs[i].x_rdata);
      end
      check($sformatf("v%0d cnt", i), DW'(outst_cnt), DW'(vecs[i].x_cnt));
    end

    // 16 back-to-back tagged reads, controller returns 20 cycles after each accept
    for (int c = 0; c < 40; c++) begin
      bus.cmd_valid   = (c < 16);
      bus.cmd_we      = 1'b0;
      bus.cmd_addr    = AW'(c + 100);
      bus.cmd_tag     = TW'(c);
      bus.usr_rd_dvld = (c >= 20 && c < 36);
      bus.usr_rd_data = 72'hF00 + DW'(c - 20);
      step();
      if (c < 16) check($sformatf("burst rd_strb c%0d", c), DW'(bus.usr_rd_strb), 72'd1);
      if (c == 14) check("burst ready at 15", DW'(bus.cmd_ready), 72'd1);
      if (c == 15) begin
        check("burst ready full", DW'(bus.cmd_ready), 72'd0);
        check("burst cnt full", DW'(outst_cnt), 72'd16);
      end
      if (c == 16) check("burst rd_strb end", DW'(bus.usr_rd_strb), 72'd0);
      if (c >= 20 && c < 36) begin
        check($sformatf("burst rsp_valid c%0d", c), DW'(bus.rsp_valid), 72'd1);
        check($sformatf("burst rsp_tag c%0d", c), DW'(bus.rsp_tag), DW'(c - 20));
        check($sformatf("burst rsp_data c%0d", c), bus.rsp_data, 72'hF00 + DW'(c - 20));
      end
      if (c == 20) check("burst ready reopen", DW'(bus.cmd_ready), 72'd1);
      if (c == 36) check("burst rsp_valid end", DW'(bus.rsp_valid), 72'd0);
    end
    check("burst cnt zero", DW'(outst_cnt), 72'd0);

    // Simultaneous read accept and dvld at outst_cnt=5
    for (int k = 1; k <= 5; k++) begin
      rd(TW'(k), 1'b0, '0);
      step();
    end
    check("sim cnt5", DW'(outst_cnt), 72'd5);
    rd(4'd6, 1'b1, 72'hA1);
    step();
    check("sim cnt held", DW'(outst_cnt), 72'd5);
    check("sim rd_strb", DW'(bus.usr_rd_strb), 72'd1);
    check("sim rsp_tag", DW'(bus.rsp_tag), 72'd1);
    for (int k = 2; k <= 6; k++) begin
      ret(DW'(k));
      step();
      check($sformatf("sim ret tag%0d", k), DW'(bus.rsp_tag), DW'(k));
      check($sformatf("sim ret cnt%0d", k), DW'(outst_cnt), DW'(6 - k));
    end

    // Unexpected dvld with empty FIFO
    ret(72'hBAD);
    step();
    check("unexp rsp_valid", DW'(bus.rsp_valid), 72'd1);
    check("unexp rsp_tag", DW'(bus.rsp_tag), 72'd0);
    check("unexp rsp_data", bus.rsp_data, 72'hBAD);
    check("unexp err", DW'(err_unexp), 72'd1);
    check("unexp cnt", DW'(outst_cnt), 72'd0);
    idle();
    step();
    check("unexp sticky", DW'(err_unexp), 72'd1);
    check("unexp no underflow", DW'(outst_cnt), 72'd0);

    // phy_rdy drop with 3 reads outstanding
    for (int k = 7; k <= 9; k++) begin
      rd(TW'(k), 1'b0, '0);
      step();
    end
    idle();
    phy_rdy = 1'b0;
    step();
    check("drain ready", DW'(bus.cmd_ready), 72'd0);
    check("drain state", DW'(dut.state_q), DW'(DRAIN));
    step();
    step();
    check("drain hold", DW'(dut.state_q), DW'(DRAIN));
    for (int k = 7; k <= 9; k++) begin
      ret(DW'(k) + 72'h500);
      step();
      check($sformatf("drain rsp_tag%0d", k), DW'(bus.rsp_tag), DW'(k));
      check($sformatf("drain rsp_data%0d", k), bus.rsp_data, DW'(k) + 72'h500);
    end
    idle();
    step();
    check("drain to wait_rdy", DW'(dut.state_q), DW'(WAIT_RDY));
    check("drain cnt", DW'(outst_cnt), 72'd0);

    // Reset with 3 reads outstanding
    phy_rdy = 1'b1;
    step();
    check("rerun ready", DW'(bus.cmd_ready), 72'd1);
    for (int k = 1; k <= 3; k++) begin
      rd(TW'(k), 1'b0, '0);
      step();
    end
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid rst ready", DW'(bus.cmd_ready), 72'd0);
    check("mid rst cnt", DW'(outst_cnt), 72'd0);
    check("mid rst addr", DW'(bus.usr_addr), 72'd0);
    check("mid rst wdata", bus.usr_wr_data, 72'd0);
    check("mid rst be", DW'(bus.usr_wr_be), 72'd0);
    check("mid rst rd_strb", DW'(bus.usr_rd_strb), 72'd0);
    check("mid rst rsp_data", bus.rsp_data, 72'd0);
    check("mid rst rsp_tag", DW'(bus.rsp_tag), 72'd0);
    check("mid rst err_unexp", DW'(err_unexp), 72'd0);
    check("mid rst err_timeout", DW'(err_timeout), 72'd0);

    // Read watchdog
    step();
    check("to ready", DW'(bus.cmd_ready), 72'd1);
    rd(4'd4, 1'b0, '0);
    step();
    idle();
    for (int k = 1; k < RT; k++) step();
    check("to not yet", DW'(err_timeout), 72'd0);
    check("to ready before", DW'(bus.cmd_ready), 72'd1);
    step();
    check("to err", DW'(err_timeout), 72'd1);
    check("to ready low", DW'(bus.cmd_ready), 72'd0);
    check("to state", DW'(dut.state_q), DW'(ERR));
    rd(4'd5, 1'b0, '0);
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("to hold ready c%0d", k), DW'(bus.cmd_ready), 72'd0);
    end
    check("to no strobe", DW'(bus.usr_rd_strb), 72'd0);
    ret(72'hC0);
    step();
    check("to fwd rsp_valid", DW'(bus.rsp_valid), 72'd1);
    check("to fwd rsp_tag", DW'(bus.rsp_tag), 72'd4);
    check("to fwd cnt", DW'(outst_cnt), 72'd0);
    idle();
    step();
    check("to sticky", DW'(err_timeout), 72'd1);
    check("to still err", DW'(bus.cmd_ready), 72'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("to cleared", DW'(err_timeout), 72'd0);
    step();
    check("to recover ready", DW'(bus.cmd_ready), 72'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
